// File: rtl/cpu_clock_ctrl.sv
// ============================================================================
//  Module      : cpu_clock_ctrl
//  Description : Single-clock CPU enable generator with four selectable rates,
//                run/pause control and an optional debounced single-step
//                button (enabled by defining CPU_CLOCK_CTRL_STEP_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_clock_ctrl #(
    parameter int unsigned DIV0     = 1,
    parameter int unsigned DIV1     = 1_000,
    parameter int unsigned DIV2     = 100_000,
    parameter int unsigned DIV3     = 5_000_000,
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned DEBOUNCE = 500_000,
    parameter int unsigned TICK_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              run,
    input  logic              step_btn,
    output logic              cpu_en,
    output logic              paused,
    output logic              step_db,
    output logic [TICK_W-1:0] tick_count
);

`ifdef CPU_CLOCK_CTRL_STEP_EN
    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_RUNNING = 2'd1
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    div_m1;
    logic                cpu_en_q, cpu_en_d;
    logic                paused_q, paused_d;
    logic [1:0]          mode_q;
    logic [TICK_W-1:0]   tick_q, tick_d;

    // Terminal count follows the registered mode so a change is seen one cycle later.
    always_comb begin
        case (mode_q)
            2'd0:    div_m1 = CNT_W'(DIV0 - 1);
            2'd1:    div_m1 = CNT_W'(DIV1 - 1);
            2'd2:    div_m1 = CNT_W'(DIV2 - 1);
            default: div_m1 = CNT_W'(DIV3 - 1);
        endcase
    end

`ifdef CPU_CLOCK_CTRL_STEP_EN
    localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic            sync1_q, btn_s_q;
    logic            step_db_q, step_db_d, step_db_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            step_req;

    always_comb begin
        step_db_d = step_db_q;
        db_cnt_d  = '0;
        if (btn_s_q != step_db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                step_db_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q        <= 1'b0;
            btn_s_q        <= 1'b0;
            step_db_q      <= 1'b0;
            step_db_prev_q <= 1'b0;
            db_cnt_q       <= '0;
        end else begin
            sync1_q        <= step_btn;
            btn_s_q        <= sync1_q;
            step_db_q      <= step_db_d;
            step_db_prev_q <= step_db_q;
            db_cnt_q       <= db_cnt_d;
        end
    end

    assign step_req = step_db_q & ~step_db_prev_q;
    assign step_db  = step_db_q;
`else
    logic unused_step_btn;
    assign unused_step_btn = step_btn;
    assign step_db         = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        cpu_en_d = 1'b0;
        tick_d   = cpu_en_q ? tick_q + TICK_W'(1) : tick_q;
        case (state_q)
            ST_RUNNING: begin
                if (!run) begin
                    state_d = ST_PAUSED;
                end else if (mode != mode_q) begin
                    cnt_d = '0;
                end else if (cnt_q == div_m1) begin
                    cpu_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef CPU_CLOCK_CTRL_STEP_EN
            ST_STEP: begin
                state_d = run ? ST_RUNNING : ST_PAUSED;
            end
`endif
            default: begin
                if (run) begin
                    state_d = ST_RUNNING;
`ifdef CPU_CLOCK_CTRL_STEP_EN
                end else if (step_req) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
`endif
                end
            end
        endcase
        paused_d = (state_d != ST_RUNNING);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_PAUSED;
            cnt_q    <= '0;
            cpu_en_q <= 1'b0;
            paused_q <= 1'b1;
            mode_q   <= 2'd0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cpu_en_q <= cpu_en_d;
            paused_q <= paused_d;
            mode_q   <= mode;
            tick_q   <= tick_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign paused     = paused_q;
    assign tick_count = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
// ============================================================================
//  Module      : tb_cpu_clock_ctrl
//  Description : Self-checking bench for cpu_clock_ctrl against a cycle-count
//                reference model; step checks follow CPU_CLOCK_CTRL_STEP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_clock_ctrl;

    localparam int TICK_W = 4;
    localparam int DEB    = 8;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              run      = 1'b0;
    logic              step_btn = 1'b0;
    logic [1:0]        mode     = 2'd0;
    logic              cpu_en;
    logic              paused;
    logic              step_db;
    logic [TICK_W-1:0] tick_count;

    always #5 clk = ~clk;

    cpu_clock_ctrl #(
        .DIV0(1), .DIV1(4), .DIV2(7), .DIV3(16),
        .CNT_W(8), .DEBOUNCE(DEB), .TICK_W(TICK_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .run       (run),
        .step_btn  (step_btn),
        .cpu_en    (cpu_en),
        .paused    (paused),
        .step_db   (step_db),
        .tick_count(tick_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: k counts edges since the rate divider was restarted,
    // and a pulse is due whenever k is a whole multiple of the period.
    int unsigned divs [4] = '{1, 4, 7, 16};
    bit m_running, m_stepping, m_en;
    int m_mq, m_k, m_tick;
    bit m_s1, m_s2, m_db, m_dbp;
    int m_dc;

    function automatic void model_edge();
        bit req;
        bit en_n;
        if (!reset) begin
            m_running = 0; m_stepping = 0; m_en = 0; m_mq = 0; m_k = 0; m_tick = 0;
            m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_dc = 0;
            return;
        end
        m_tick = (m_tick + int'(m_en)) % (1 << TICK_W);
        req    = m_db && !m_dbp;
        en_n   = 0;
        if (m_running) begin
            if (!run) m_running = 0;
            else if (int'(mode) != m_mq) m_k = 0;
            else begin
                m_k++;
                en_n = (m_k % divs[m_mq]) == 0;
            end
        end else if (m_stepping) begin
            m_stepping = 0;
            if (run) begin m_running = 1; m_k = 0; end
        end else if (run) begin
            m_running = 1; m_k = 0;
        end else if (req) begin
            m_stepping = 1; en_n = 1;
        end
        m_en = en_n;
        m_mq = int'(mode);
`ifdef CPU_CLOCK_CTRL_STEP_EN
        m_dbp = m_db;
        if (m_s2 != m_db) begin
            m_dc++;
            if (m_dc == DEB) begin m_db = m_s2; m_dc = 0; end
        end else begin
            m_dc = 0;
        end
        m_s2 = m_s1;
        m_s1 = step_btn;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cpu_en",  32'(cpu_en),     32'(m_en));
        check("paused",  32'(paused),     32'(!m_running));
        check("step_db", 32'(step_db),    32'(m_db));
        check("tick",    32'(tick_count), 32'(m_tick));
    endtask

    task automatic count_pulses(input int cycles, output int c);
        c = 0;
        repeat (cycles) begin
            cycle();
            if (cpu_en === 1'b1) c++;
        end
    endtask

    // n is the number of edges from the first one that samples the new inputs.
    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (cpu_en !== 1'b1 && n < limit);
    endtask

    initial begin
        int c;
        int n;
        int first;

        run  = 1'b1;
        mode = 2'd1;
        repeat (3) cycle();

        reset = 1'b1;
        cycle();
        count_pulses(40, c);
        check("free_pulses", 32'(c), 32'd10);
        cycle();
        check("free_tick", 32'(tick_count), 32'd10);

        mode = 2'd0;
        count_pulses(20, c);
        check("m0_pulses", 32'(c), 32'd19);

        mode = 2'd3;
        wait_pulse(40, n);
        check("m3_first", 32'(n), 32'd17);
        repeat (5) cycle();
        mode = 2'd2;
        wait_pulse(40, n);
        check("modesw_lat", 32'(n), 32'd8);
        wait_pulse(40, n);
        check("modesw_period", 32'(n), 32'd7);

        repeat (2) cycle();
        run = 1'b0;
        count_pulses(10, c);
        check("pause_pulses", 32'(c), 32'd0);
        run = 1'b1;
        wait_pulse(40, n);
        check("resume_lat", 32'(n), 32'd8);

        mode = 2'd1;
        wait_pulse(40, n);
        step_btn = 1'b1;
        count_pulses(20, c);
        step_btn = 1'b0;
        count_pulses(20, n);
        check("step_in_run", 32'(c + n), 32'd10);

        run = 1'b0;
        repeat (20) cycle();
        step_btn = 1'b1;
        count_pulses(5, c);
        step_btn = 1'b0;
        count_pulses(15, n);
        check("glitch_pulses", 32'(c + n), 32'd0);

        step_btn = 1'b1;
        c     = 0;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (cpu_en === 1'b1) begin
                c++;
                if (first == 0) first = i;
            end
        end
        step_btn = 1'b0;
`ifdef CPU_CLOCK_CTRL_STEP_EN
        check("step_pulses", 32'(c), 32'd1);
        check("step_lat", 32'(first), 32'd11);
`else
        check("step_pulses", 32'(c), 32'd0);
        check("step_db_off", 32'(step_db), 32'd0);
`endif
        count_pulses(20, c);
        check("release_pulses", 32'(c), 32'd0);

        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) step_btn = ~step_btn;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
